// File: rtl/reduction_mux_pkg.sv
// ----------------------------------------------------------------------------
// reduction_mux_pkg
// Shared helpers for the reduction-mux family of blocks.
//   clog2    : ceiling log2 usable in constant expressions
//   seg_of   : number of input words per output segment
//   sel_w_of : width of one per-output select field; one bit wider than
//              clog2(SEG) so that "out of range" select values exist and
//              can be used to force an output to zero
// ----------------------------------------------------------------------------
package reduction_mux_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int seg_of(input int num_in, input int num_out);
        return num_in / num_out;
    endfunction

    function automatic int sel_w_of(input int num_in, input int num_out);
        return clog2(seg_of(num_in, num_out)) + 1;
    endfunction

endpackage

// File: rtl/reduction_mux_skid.sv
// ----------------------------------------------------------------------------
// reduction_mux_skid
// Two-entry FIFO output buffer with valid/ready on both sides.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   in_valid/in_ready   : upstream handshake, in_data captured when both high
//   in_data  [WIDTH]    : word to store
//   out_valid/out_ready : downstream handshake, entry released when both high
//   out_data [WIDTH]    : oldest stored entry
//
// Handshake: a transfer happens on a rising edge where valid && ready. Once
// out_valid is high, out_valid/out_data hold until out_ready is seen high.
// in_ready depends only on the registered count, never on out_ready, so no
// combinational path runs from the downstream ready to the upstream ready.
// ----------------------------------------------------------------------------
module reduction_mux_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [1:0]       count;
    logic [WIDTH-1:0] entry0;   // oldest entry, drives out_data
    logic [WIDTH-1:0] entry1;   // second entry, valid only when count == 2
    logic             push;
    logic             pop;

    assign in_ready  = (count < 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = entry0;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 2'd0;
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            case ({push, pop})
                2'b11: begin
                    // Push and pop together is only possible at count == 1
                    // (count 2 blocks push, count 0 blocks pop): the new
                    // word replaces the departing head, count unchanged.
                    entry0 <= in_data;
                end
                2'b10: begin
                    if (count == 2'd0) begin
                        entry0 <= in_data;
                    end else begin
                        entry1 <= in_data;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    entry0 <= entry1;
                    count  <= count - 2'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/reduction_mux_pipe.sv
// ----------------------------------------------------------------------------
// reduction_mux_pipe
// Segmented word selector with a one-cycle, two-entry buffered output.
// The NUM_IN input words are split into NUM_OUT segments of SEG words; output
// k picks word s of segment k, where s is config field k. Field values >= SEG
// force output k to zero.
//   clk, rst_n          : clock (rising edge), async active-low reset
//   i_cfg_load, i_sel   : load the config register (field k at k*SEL_W)
//   i_valid/o_ready     : input handshake for i_data (word j at j*W)
//   o_valid/i_ready     : output handshake for o_data (word k at k*W)
//   o_cfg               : current config register contents
//
// Handshake: transfers occur on a rising edge with valid && ready. The
// selection is evaluated from i_data and the config register value before the
// edge, so a config load on the same edge as a transfer affects only later
// transfers, and stored results never change with config.
// ----------------------------------------------------------------------------
module reduction_mux_pipe
    import reduction_mux_pkg::*;
#(
    parameter  int W       = 32,
    parameter  int NUM_IN  = 8,
    parameter  int NUM_OUT = 2,
    localparam int SEG     = seg_of(NUM_IN, NUM_OUT),
    localparam int SEL_W   = sel_w_of(NUM_IN, NUM_OUT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_cfg_load,
    input  logic [NUM_OUT*SEL_W-1:0] i_sel,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [NUM_IN*W-1:0]      i_data,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [NUM_OUT*W-1:0]     o_data,
    output logic [NUM_OUT*SEL_W-1:0] o_cfg
);

    logic [NUM_OUT*SEL_W-1:0] cfg_q;
    logic [NUM_OUT*W-1:0]     sel_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_q <= '0;
        end else if (i_cfg_load) begin
            cfg_q <= i_sel;
        end
    end

    assign o_cfg = cfg_q;

    // Compare the field against every legal in-segment index instead of
    // indexing with it directly: an out-of-range field matches nothing and
    // leaves the zero default, and no read ever leaves segment k.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            for (int s = 0; s < SEG; s++) begin
                if (cfg_q[k*SEL_W +: SEL_W] == SEL_W'(s)) begin
                    sel_data[k*W +: W] = i_data[(k*SEG + s)*W +: W];
                end
            end
        end
    end

    reduction_mux_skid #(
        .WIDTH (NUM_OUT*W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (i_valid),
        .in_ready  (o_ready),
        .in_data   (sel_data),
        .out_valid (o_valid),
        .out_ready (i_ready),
        .out_data  (o_data)
    );

endmodule

// File: tb/tb_reduction_mux_pipe.sv
// ----------------------------------------------------------------------------
// tb_reduction_mux_pipe
// Scoreboard bench: the driver pushes the expected output word for every
// accepted input into exp_q; an independent monitor compares and pops
// whenever the DUT presents output.
// ----------------------------------------------------------------------------
module tb_reduction_mux_pipe;

    localparam int W       = 32;
    localparam int NUM_IN  = 8;
    localparam int NUM_OUT = 2;
    localparam int SEG     = NUM_IN / NUM_OUT;
    localparam int SEL_W   = 3;
    localparam int DW      = NUM_OUT * W;
    localparam int IW      = NUM_IN * W;
    localparam int CW      = NUM_OUT * SEL_W;

    logic          clk;
    logic          rst_n;
    logic          i_cfg_load;
    logic [CW-1:0] i_sel;
    logic          i_valid;
    logic          o_ready;
    logic [IW-1:0] i_data;
    logic          o_valid;
    logic          i_ready;
    logic [DW-1:0] o_data;
    logic [CW-1:0] o_cfg;

    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] model_cfg;
    int            n_tests;
    int            n_fail;
    int            n_out;

    reduction_mux_pipe #(
        .W       (W),
        .NUM_IN  (NUM_IN),
        .NUM_OUT (NUM_OUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cfg_load (i_cfg_load),
        .i_sel      (i_sel),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_cfg      (o_cfg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Output k is word (k*SEG + field_k) of the input list, or zero when the
    // field does not name a word of segment k.
    function automatic logic [DW-1:0] model(input logic [IW-1:0] d, input logic [CW-1:0] cfg);
        logic [W-1:0]  words [NUM_IN];
        logic [DW-1:0] res;
        int            s;
        for (int j = 0; j < NUM_IN; j++) words[j] = d[j*W +: W];
        res = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            s = int'(cfg[k*SEL_W +: SEL_W]);
            if (s < SEG) res[k*W +: W] = words[k*SEG + s];
        end
        return res;
    endfunction

    function automatic logic [IW-1:0] rand_data();
        logic [IW-1:0] d;
        for (int j = 0; j < NUM_IN; j++) d[j*W +: W] = $urandom();
        return d;
    endfunction

    function automatic logic [IW-1:0] inc_data(input logic [W-1:0] base);
        logic [IW-1:0] d;
        for (int j = 0; j < NUM_IN; j++) d[j*W +: W] = base + W'(j);
        return d;
    endfunction

    function automatic logic [CW-1:0] mk_cfg(input int f1, input int f0);
        logic [CW-1:0] c;
        c = '0;
        c[0 +: SEL_W]     = SEL_W'(f0);
        c[SEL_W +: SEL_W] = SEL_W'(f1);
        return c;
    endfunction

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- driver ----------------
    // Called at posedge+1; inputs are applied, acceptance is recorded after
    // the monitor has looked at this cycle, and the call returns at posedge+1.
    task automatic drive(input logic v, input logic [IW-1:0] d, input logic ld,
                         input logic [CW-1:0] sel, input logic rdy);
        i_valid    = v;
        i_data     = d;
        i_cfg_load = ld;
        i_sel      = sel;
        i_ready    = rdy;
        @(negedge clk);
        #1;
        if (i_valid && o_ready) exp_q.push_back(model(i_data, model_cfg));
        if (i_cfg_load) model_cfg = i_sel;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, '0, 1'b0, '0, rdy);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("o_valid_vs_occupancy", 64'(o_valid), 64'(exp_q.size() != 0));
            check("o_ready_vs_occupancy", 64'(o_ready), 64'(exp_q.size() < 2));
            check("o_cfg", 64'(o_cfg), 64'(model_cfg));
            if (o_valid && exp_q.size() > 0) begin
                check("o_data", 64'(o_data), 64'(exp_q[0]));
                if (i_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int out_before;
        n_tests    = 0;
        n_fail     = 0;
        n_out      = 0;
        model_cfg  = '0;
        rst_n      = 1'b0;
        i_cfg_load = 1'b0;
        i_sel      = '0;
        i_valid    = 1'b0;
        i_data     = '0;
        i_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_o_valid", 64'(o_valid), 64'd0);
        check("reset_o_data", 64'(o_data), 64'd0);
        check("reset_o_cfg", 64'(o_cfg), 64'd0);
        rst_n = 1'b1;
        #1;
        check("reset_o_ready", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic selection: field0=1, field1=2, words 0x100+j.
        drive(1'b0, '0, 1'b1, mk_cfg(2, 1), 1'b1);
        drive(1'b1, inc_data(32'h100), 1'b0, '0, 1'b1);
        check("basic_valid", 64'(o_valid), 64'd1);
        check("basic_data", 64'(o_data), 64'h00000106_00000101);
        idle(1'b1);

        // Out-of-range fields: field0=SEG, field1=7 give zeros.
        drive(1'b0, '0, 1'b1, mk_cfg(7, SEG), 1'b1);
        drive(1'b1, rand_data(), 1'b0, '0, 1'b1);
        check("oor_data", 64'(o_data), 64'd0);
        idle(1'b1);

        // Backpressure: A, B buffered, C refused, then drained in order.
        drive(1'b0, '0, 1'b1, mk_cfg(1, 3), 1'b1);
        drive(1'b1, inc_data(32'hA00), 1'b0, '0, 1'b0);
        drive(1'b1, inc_data(32'hB00), 1'b0, '0, 1'b0);
        check("full_o_ready", 64'(o_ready), 64'd0);
        drive(1'b1, inc_data(32'hC00), 1'b0, '0, 1'b0);
        check("full_head_is_A", 64'(o_data), 64'h00000A05_00000A03);
        idle(1'b1);
        check("drain_head_is_B", 64'(o_data), 64'h00000B05_00000B03);
        idle(1'b1);
        check("drained_o_ready", 64'(o_ready), 64'd1);
        check("drained_o_valid", 64'(o_valid), 64'd0);

        // Config load on the same edge as a push uses the old config.
        drive(1'b0, '0, 1'b1, mk_cfg(0, 0), 1'b1);
        drive(1'b1, inc_data(32'h200), 1'b1, mk_cfg(3, 3), 1'b1);
        check("cfg_edge_A_old", 64'(o_data), 64'h00000204_00000200);
        drive(1'b1, inc_data(32'h300), 1'b0, '0, 1'b1);
        check("cfg_edge_B_new", 64'(o_data), 64'h00000307_00000303);

        // Streaming: one output per cycle, occupancy stays at one.
        out_before = n_out;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, rand_data(), 1'b0, '0, 1'b1);
            check("stream_o_valid", 64'(o_valid), 64'd1);
            check("stream_o_ready", 64'(o_ready), 64'd1);
        end
        check("stream_out_count", 64'(n_out - out_before), 64'd16);
        idle(1'b1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), rand_data(), ($urandom_range(0, 3) == 0),
                  mk_cfg($urandom_range(0, 7), $urandom_range(0, 7)), ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 8 && exp_q.size() != 0; i++) idle(1'b1);
        check("random_drained", 64'(exp_q.size()), 64'd0);

        // Reset with a full buffer.
        drive(1'b0, '0, 1'b1, mk_cfg(2, 3), 1'b0);
        drive(1'b1, rand_data(), 1'b0, '0, 1'b0);
        drive(1'b1, rand_data(), 1'b0, '0, 1'b0);
        check("prereset_full", 64'(o_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        check("midreset_o_valid", 64'(o_valid), 64'd0);
        check("midreset_o_data", 64'(o_data), 64'd0);
        check("midreset_o_cfg", 64'(o_cfg), 64'd0);
        exp_q.delete();
        model_cfg = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("postreset_o_ready", 64'(o_ready), 64'd1);
        drive(1'b1, inc_data(32'h400), 1'b0, '0, 1'b1);
        check("postreset_first", 64'(o_data), 64'h00000404_00000400);
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) idle(1'b1);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
